// File: rtl/int_math_seq_pkg.sv
// Shared types for the iterative integer math unit: operation codes, FSM states
// and the per-operation iteration count.
package int_math_seq_pkg;

  typedef enum logic [1:0] {
    ModeClog2 = 2'd0,
    ModeFlog2 = 2'd1,
    ModeIsqrt = 2'd2,
    ModeRsvd  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Number of BUSY iterations before the result is latched; the reserved
  // mode does none, so its result appears one cycle after accept.
  function automatic int unsigned iter_count(mode_e mode, int unsigned width);
    case (mode)
      ModeClog2, ModeFlog2: return width;
      ModeIsqrt:            return width / 2;
      default:              return 0;
    endcase
  endfunction

endpackage

// File: rtl/int_math_seq_isqrt_step.sv
// One restoring square-root iteration: bring down the next operand bit pair,
// try subtracting 4*root+1 and append the resulting root bit.
module int_math_seq_isqrt_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH/2+1:0] rem_in,
  input  logic [WIDTH/2-1:0] root_in,
  input  logic [1:0]         pair_in,
  output logic [WIDTH/2+1:0] rem_out,
  output logic [WIDTH/2-1:0] root_out
);

  localparam int unsigned HalfW = WIDTH / 2;
  localparam int unsigned RemW  = HalfW + 2;

  logic [RemW-1:0] w_cand;
  logic [RemW-1:0] w_trial;

  // Trial subtraction; the remainder bound keeps the shifted-out bits zero.
  always_comb begin
    w_cand  = (rem_in << 2) | {{(RemW-2){1'b0}}, pair_in};
    w_trial = {root_in, 2'b01};
    if (w_cand >= w_trial) begin
      rem_out  = w_cand - w_trial;
      root_out = (root_in << 1) | {{(HalfW-1){1'b0}}, 1'b1};
    end else begin
      rem_out  = w_cand;
      root_out = root_in << 1;
    end
  end

endmodule

// File: rtl/int_math_seq.sv
// Run-time iterative CLOG2 / FLOG2 / ISQRT unit with valid/ready on both sides.
// One operation in flight; the result is held until downstream accepts it.
module int_math_seq
  import int_math_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int unsigned CntW  = $clog2(WIDTH) + 1;
  localparam int unsigned HalfW = WIDTH / 2;
  localparam int unsigned RemW  = HalfW + 2;

  state_e           r_state;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_opnd;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  r_limit;
  logic             r_found;
  logic [CntW-1:0]  r_idx;
  logic [RemW-1:0]  r_rem;
  logic [HalfW-1:0] r_root;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;

  logic [RemW-1:0]  w_rem_nxt;
  logic [HalfW-1:0] w_root_nxt;

  int_math_seq_isqrt_step #(
    .WIDTH (WIDTH)
  ) u_isqrt_step (
    .rem_in   (r_rem),
    .root_in  (r_root),
    .pair_in  (r_opnd[WIDTH-1 -: 2]),
    .rem_out  (w_rem_nxt),
    .root_out (w_root_nxt)
  );

  // Accept only when idle; depends on state alone.
  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  // Control FSM, operand shifter, iteration counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_mode      <= ModeClog2;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_limit     <= '0;
      r_found     <= 1'b0;
      r_idx       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_mode  <= mode_e'(in_mode);
            r_cnt   <= '0;
            r_limit <= CntW'(iter_count(mode_e'(in_mode), WIDTH));
            r_found <= 1'b0;
            r_idx   <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            // CLOG2(x) = FLOG2(x-1)+1; x<=1 leaves nothing set so the result is 0.
            if (mode_e'(in_mode) == ModeClog2) begin
              r_opnd <= (in_data == '0) ? '0 : in_data - WIDTH'(1);
            end else begin
              r_opnd <= in_data;
            end
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (r_cnt == r_limit) begin
            r_out_valid <= 1'b1;
            r_state     <= StDone;
            case (r_mode)
              ModeClog2: begin
                r_out_data <= r_found ? WIDTH'(r_idx) + WIDTH'(1) : '0;
                r_out_err  <= 1'b0;
              end
              ModeFlog2: begin
                r_out_data <= WIDTH'(r_idx);
                r_out_err  <= ~r_found;
              end
              ModeIsqrt: begin
                r_out_data <= {{(WIDTH-HalfW){1'b0}}, r_root};
                r_out_err  <= 1'b0;
              end
              default: begin
                r_out_data <= '0;
                r_out_err  <= 1'b1;
              end
            endcase
          end else begin
            r_cnt <= r_cnt + CntW'(1);
            case (r_mode)
              ModeClog2, ModeFlog2: begin
                // LSB-first scan; the last set bit seen is the highest one.
                if (r_opnd[0]) begin
                  r_found <= 1'b1;
                  r_idx   <= r_cnt;
                end
                r_opnd <= r_opnd >> 1;
              end
              ModeIsqrt: begin
                r_rem  <= w_rem_nxt;
                r_root <= w_root_nxt;
                r_opnd <= r_opnd << 2;
              end
              default: ;
            endcase
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_int_math_seq.sv
// Scoreboard bench for int_math_seq: directed vectors, hold/abort scenarios
// and randomized operations against a plain-arithmetic reference model.
module tb_int_math_seq;

  localparam int unsigned WIDTH = 32;
  localparam int          NRAND = 1500;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  int_math_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               lat;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  bit   prev_v = 1'b0;
  bit   hold_low = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit values.
  function automatic longint m_flog2(input longint x);
    longint r = 0;
    for (int i = 0; i < WIDTH; i++) if (x >= (longint'(1) << i)) r = i;
    return r;
  endfunction

  function automatic longint m_clog2(input longint x);
    longint r = 0;
    while ((longint'(1) << r) < x) r++;
    return r;
  endfunction

  function automatic longint m_isqrt(input longint x);
    longint r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int m_lat(input logic [1:0] mode);
    case (mode)
      2'd0, 2'd1: return WIDTH + 1;
      2'd2:       return WIDTH / 2 + 1;
      default:    return 1;
    endcase
  endfunction

  // Present one operation, wait (bounded) for acceptance, push its expectation.
  task automatic issue(input logic [1:0] mode, input logic [WIDTH-1:0] data,
                       input logic [WIDTH-1:0] edata, input logic eerr);
    int   waitc = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.data = edata;
    e.err  = eerr;
    e.lat  = m_lat(mode);
    e.acc  = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;  // must not disturb the captured operand
    in_mode  = 2'($urandom);
  endtask

  task automatic issue_model(input logic [1:0] mode, input logic [WIDTH-1:0] data);
    longint x = longint'(data);
    case (mode)
      2'd0:    issue(mode, data, WIDTH'(m_clog2(x)), 1'b0);
      2'd1:    issue(mode, data, WIDTH'(m_flog2(x)), (x == 0));
      2'd2:    issue(mode, data, WIDTH'(m_isqrt(x)), 1'b0);
      default: issue(mode, data, '0, 1'b1);
    endcase
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Downstream back-pressure, changed just after each active edge.
  always @(posedge clk) begin
    #2;
    out_ready = hold_low ? 1'b0 : ($urandom_range(99) < 75);
  end

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) first_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_err", out_err, mon_e.err);
          check("latency", first_cyc - mon_e.acc, mon_e.lat);
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    int               k;
    bit               saw_v;
    int               n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    // Directed vectors with known answers.
    issue(2'd1, 32'h0001_0000, 32'd16, 1'b0);
    issue(2'd1, 32'h0000_0000, 32'd0, 1'b1);
    issue(2'd0, 32'h0000_0000, 32'd0, 1'b0);
    issue(2'd0, 32'h0000_0001, 32'd0, 1'b0);
    issue(2'd0, 32'h0000_0002, 32'd1, 1'b0);
    issue(2'd0, 32'h0000_0005, 32'd3, 1'b0);
    issue(2'd0, 32'h8000_0000, 32'd31, 1'b0);
    issue(2'd0, 32'hFFFF_FFFF, 32'd32, 1'b0);
    issue(2'd2, 32'd0, 32'd0, 1'b0);
    issue(2'd2, 32'd15, 32'd3, 1'b0);
    issue(2'd2, 32'd16, 32'd4, 1'b0);
    issue(2'd2, 32'd1000000, 32'd1000, 1'b0);
    issue(2'd2, 32'hFFFF_FFFF, 32'd65535, 1'b0);
    issue(2'd3, 32'h0000_1234, 32'd0, 1'b1);
    issue(2'd1, 32'hFFFF_FFFF, 32'd31, 1'b0);
    wait_drain(500);

    // Back-pressure: result must stay put and no new op accepted.
    hold_low = 1'b1;
    issue(2'd2, 32'd1000000, 32'd1000, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid_seen", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("hold_out_data", out_data, 1000);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    hold_low = 1'b0;
    wait_drain(100);

    // Reset mid-ISQRT aborts and drops the result.
    issue(2'd2, 32'd1000000, 32'd1000, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    saw_v = 1'b0;
    repeat (25) begin
      @(negedge clk);
      saw_v = saw_v | out_valid;
    end
    check("abort_no_result", saw_v, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < NRAND; i++) begin
      k = $urandom_range(WIDTH - 1);
      case ($urandom_range(3))
        0:       d = $urandom;
        1:       d = WIDTH'($urandom_range(20));
        2:       d = WIDTH'(1) << k;
        default: d = (WIDTH'(1) << k) + WIDTH'($urandom_range(2)) - WIDTH'(1);
      endcase
      issue_model(($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2)), d);
    end
    wait_drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
